// File: rtl/input_sync_debounce_if.sv
// -----------------------------------------------------------------------------
// input_sync_debounce_if
//
// Purpose : bundles the raw input bus and the conditioned outputs of
//           input_sync_debounce so the block and its environment connect
//           through one port.
//
// Signals :
//   raw_in      [WIDTH]  asynchronous raw levels into the conditioner
//   clean_out   [WIDTH]  debounced, synchronized levels (registered)
//   changed     [1]      one-cycle strobe, high on the cycle clean_out moved
//   change_mask [WIDTH]  which clean_out bits toggled on that edge
//
// Modports:
//   master : the source of raw_in and consumer of the conditioned levels
//   slave  : the conditioner itself
//
// Transfer semantics: there is no valid/ready pair. raw_in is sampled every
// clock with no acknowledgement. clean_out is a level that is always valid
// after reset. changed/change_mask form a single-cycle event that the
// consumer cannot stall; it is asserted on exactly the cycle clean_out
// differs from its previous value and is all-zero otherwise.
// -----------------------------------------------------------------------------
interface input_sync_debounce_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] clean_out;
    logic             changed;
    logic [WIDTH-1:0] change_mask;

    modport master (
        output raw_in,
        input  clean_out,
        input  changed,
        input  change_mask
    );

    modport slave (
        input  raw_in,
        output clean_out,
        output changed,
        output change_mask
    );
endinterface

// File: rtl/input_sync_debounce.sv
// -----------------------------------------------------------------------------
// input_sync_debounce
//
// Purpose : conditioning stage for the a/b/c -> y1..y4 expression logic.
//           Each raw asynchronous input bit passes through a two-flop
//           synchronizer and then a per-bit stability counter. The
//           debounced level only moves after the synchronized value has
//           disagreed with it for DEBOUNCE_CYCLES consecutive cycles. A
//           registered one-cycle strobe and bit mask report every move.
//
// Parameters:
//   WIDTH            number of independent input bits (>= 1)
//   DEBOUNCE_CYCLES  consecutive cycles a new level must persist (>= 1)
//
// Ports:
//   clk     in   single clock, all state on the rising edge
//   rst_n   in   asynchronous active-low reset, clears every flop
//   bus_if  slave modport of input_sync_debounce_if:
//             raw_in      in   raw asynchronous levels
//             clean_out   out  debounced levels (registered)
//             changed     out  one-cycle strobe on any clean_out change
//             change_mask out  toggled bits of clean_out, zero otherwise
//
// Latency: a raw change that is stable before edge E0 reaches sync2 at E1.
// clean_out follows at E(1+DEBOUNCE_CYCLES). Every output comes straight
// from a flop, so no combinational path runs from raw_in to an output.
// -----------------------------------------------------------------------------
module input_sync_debounce #(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input_sync_debounce_if.slave  bus_if
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("input_sync_debounce: WIDTH must be >= 1");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
            $error("input_sync_debounce: DEBOUNCE_CYCLES must be >= 1");
        end
    endgenerate

    // The counter holds 0 .. DEBOUNCE_CYCLES-1. Sizing it for
    // DEBOUNCE_CYCLES+1 values keeps it at least one bit wide when
    // DEBOUNCE_CYCLES is 1.
    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] clean_q;
    logic [WIDTH-1:0] clean_d;
    logic             changed_q;
    logic             changed_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // -------------------------------------------------------------------------
    // Synchronizer: two back-to-back flops with nothing in between, so the
    // first flop has a full cycle to settle from metastability.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus_if.raw_in;
            sync2_q <= sync1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Per-bit stability counters and next clean level.
    //
    // A bit's counter runs only while sync2 disagrees with clean_out. When
    // they agree again, for example at the end of a short glitch or after a
    // bounce back, the counter clears. The next excursion then has to prove
    // itself for the full DEBOUNCE_CYCLES cycles. The counter clears on the
    // cycle it commits, so it never passes CNT_LAST and cannot wrap.
    // Bits share no state, so a bounce on one bit never delays another.
    // -------------------------------------------------------------------------
    always_comb begin
        clean_d = clean_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    clean_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Strobe outputs are computed from the same next-state value that clean_out
    // registers. They therefore line up with the clean_out update edge and fall
    // back to zero on the following edge unless another bit commits.
    always_comb begin
        mask_d    = clean_d ^ clean_q;
        changed_d = |mask_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clean_q   <= '0;
            changed_q <= 1'b0;
            mask_q    <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            clean_q   <= clean_d;
            changed_q <= changed_d;
            mask_q    <= mask_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all registered
    // -------------------------------------------------------------------------
    assign bus_if.clean_out   = clean_q;
    assign bus_if.changed     = changed_q;
    assign bus_if.change_mask = mask_q;

endmodule

// File: tb/tb_input_sync_debounce.sv
// -----------------------------------------------------------------------------
// tb_input_sync_debounce
//
// Drives the conditioner with DEBOUNCE_CYCLES=4 (main instance) and
// DEBOUNCE_CYCLES=1 (second instance). Expected per-edge outputs are pushed
// into a queue by the driver. A monitor pops them 1 ns after each rising edge
// and compares them with the outputs.
// -----------------------------------------------------------------------------
module tb_input_sync_debounce;

    localparam int W  = 3;
    localparam int D  = 4;
    localparam int EW = 2 * W + 1;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    input_sync_debounce_if #(.WIDTH(W)) bus  ();
    input_sync_debounce_if #(.WIDTH(W)) bus1 ();

    input_sync_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    input_sync_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(1)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus1)
    );

    // ---------------------------------------------------------------- scoreboard
    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];
    string         tag_q[$];
    logic [W-1:0]  cur_clean;

    task automatic check(input string name, input logic [EW-1:0] act,
                         input logic [EW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got clean=%b changed=%b mask=%b, want clean=%b changed=%b mask=%b",
                     name, act[EW-1 -: W], act[W], act[W-1:0],
                     exp[EW-1 -: W], exp[W], exp[W-1:0]);
        end
    endtask

    // The driver pushes at most one expectation before each rising edge, so
    // the queue never holds more than one entry at a time.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            string         t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, {bus.clean_out, bus.changed, bus.change_mask}, e);
        end
    end

    // ---------------------------------------------------------------- driver tasks
    // Called at a falling edge: queue the expectation for the next rising edge,
    // then advance to the following falling edge.
    task automatic expect_edge(input logic [W-1:0] clean, input logic [W-1:0] mask,
                               input string tag);
        exp_q.push_back({clean, |mask, mask});
        tag_q.push_back(tag);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Apply a step on raw_in and hold it. Edges E0..E(D) must show the old level.
    // E(D+1) shows the new level with the strobe. E(D+2) is quiet again.
    task automatic drive_step(input logic [W-1:0] val, input logic [W-1:0] exp_mask,
                              input string tag);
        logic [W-1:0] old;
        old = cur_clean;
        bus.raw_in = val;
        for (int k = 0; k <= D; k++) expect_edge(old, '0, $sformatf("%s e%0d", tag, k));
        expect_edge(val, exp_mask, $sformatf("%s pulse", tag));
        expect_edge(val, '0, $sformatf("%s after", tag));
        cur_clean = val;
    endtask

    // ---------------------------------------------------------------- vector table
    typedef struct {
        logic [W-1:0] raw;
        logic [W-1:0] mask;
        string        tag;
    } vec_t;

    vec_t vecs[8];

    // ---------------------------------------------------------------- watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- main test
    initial begin
        vecs[0] = '{3'b001, 3'b001, "rise_b0"};
        vecs[1] = '{3'b000, 3'b001, "fall_b0"};
        vecs[2] = '{3'b110, 3'b110, "simul_110"};
        vecs[3] = '{3'b000, 3'b110, "fall_110"};
        vecs[4] = '{3'b101, 3'b101, "rise_101"};
        vecs[5] = '{3'b011, 3'b110, "swap_011"};
        vecs[6] = '{3'b111, 3'b100, "rise_b2"};
        vecs[7] = '{3'b000, 3'b111, "fall_all"};

        // Reset held with all raw inputs high: outputs must stay zero.
        rst_n       = 1'b0;
        bus.raw_in  = 3'b111;
        bus1.raw_in = 3'b111;
        cur_clean   = '0;
        #3;
        check("reset_initial", {bus.clean_out, bus.changed, bus.change_mask}, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_held", {bus.clean_out, bus.changed, bus.change_mask}, '0);
        check("reset_held_d1", {bus1.clean_out, bus1.changed, bus1.change_mask}, '0);
        bus.raw_in  = 3'b000;
        bus1.raw_in = 3'b000;
        rst_n       = 1'b1;
        for (int k = 0; k < 3; k++) expect_edge(3'b000, '0, $sformatf("idle e%0d", k));

        // Step vectors: single-bit, simultaneous and mixed transitions.
        for (int v = 0; v < 8; v++) drive_step(vecs[v].raw, vecs[v].mask, vecs[v].tag);

        // Glitch on bit 1 lasting 3 cycles (shorter than D): no change.
        bus.raw_in = 3'b010;
        for (int k = 0; k < 3 + D + 3; k++) begin
            if (k == 3) bus.raw_in = 3'b000;
            expect_edge(3'b000, '0, $sformatf("glitch e%0d", k));
        end
        // The count must be back at zero, so a real rise needs the full latency.
        drive_step(3'b010, 3'b010, "post_glitch_rise");
        drive_step(3'b000, 3'b010, "post_glitch_fall");

        // Staggered: bit 2 rises, bit 1 two cycles later -> two separate pulses.
        bus.raw_in = 3'b100;
        for (int k = 0; k <= D + 4; k++) begin
            if (k == 2) bus.raw_in = 3'b110;
            if (k < D + 1)       expect_edge(3'b000, 3'b000, $sformatf("stagger e%0d", k));
            else if (k == D + 1) expect_edge(3'b100, 3'b100, "stagger pulse1");
            else if (k == D + 2) expect_edge(3'b100, 3'b000, "stagger gap");
            else if (k == D + 3) expect_edge(3'b110, 3'b010, "stagger pulse2");
            else                 expect_edge(3'b110, 3'b000, "stagger after");
        end
        cur_clean = 3'b110;
        drive_step(3'b000, 3'b110, "stagger_fall");

        // Bounce on bit 2: 1,0,1,0,1 then held. The final rise lands before edge 4,
        // so clean_out[2] updates at edge 4+D+1.
        for (int k = 0; k < 4 + D + 4; k++) begin
            bus.raw_in = (k < 5 && k[0]) ? 3'b000 : 3'b100;
            if (k < 4 + D + 1)       expect_edge(3'b000, 3'b000, $sformatf("bounce e%0d", k));
            else if (k == 4 + D + 1) expect_edge(3'b100, 3'b100, "bounce pulse");
            else                     expect_edge(3'b100, 3'b000, $sformatf("bounce after e%0d", k));
        end
        cur_clean = 3'b100;
        drive_step(3'b000, 3'b100, "bounce_fall");

        // Reset mid-count: clean_out=110, bits counting toward 111, reset after E3.
        drive_step(3'b110, 3'b110, "pre_reset");
        bus.raw_in = 3'b111;
        for (int k = 0; k < 4; k++) expect_edge(3'b110, '0, $sformatf("midcount e%0d", k));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid", {bus.clean_out, bus.changed, bus.change_mask}, '0);
        @(negedge clk);
        check("reset_mid_held", {bus.clean_out, bus.changed, bus.change_mask}, '0);
        rst_n     = 1'b1;
        cur_clean = '0;
        drive_step(3'b111, 3'b111, "post_reset");
        drive_step(3'b000, 3'b111, "post_reset_fall");

        // DEBOUNCE_CYCLES=1 instance: a rise before E0 appears at E2.
        bus1.raw_in = 3'b001;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (k < 2)
                check($sformatf("d1 e%0d", k), {bus1.clean_out, bus1.changed, bus1.change_mask}, '0);
            else if (k == 2)
                check("d1 pulse", {bus1.clean_out, bus1.changed, bus1.change_mask}, {3'b001, 1'b1, 3'b001});
            else
                check("d1 after", {bus1.clean_out, bus1.changed, bus1.change_mask}, {3'b001, 1'b0, 3'b000});
        end
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
